// File: rtl/goal_referee.sv
// Match referee: detects goals from puck position, pulses the score and timer
// controls, and runs the IDLE/PLAY/HOLD/OVER match state machine.
module goal_referee #(
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int SCREEN_W    = 160,
  parameter int GOAL_Y_MIN  = 40,
  parameter int GOAL_Y_MAX  = 80,
  parameter int HOLD_FRAMES = 30,
  parameter int WIN_SCORE   = 6
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           frame_tick,
  input  logic [X_W-1:0] puck_x,
  input  logic [Y_W-1:0] puck_y,
  input  logic           start,
  input  logic           time_expired,
  output logic           goal_p1,
  output logic           goal_p2,
  output logic           puck_reset,
  output logic           timer_enable,
  output logic           clear_sig,
  output logic           game_over,
  output logic [1:0]     winner
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HOLD, S_OVER} state_e;

  state_e             state_q, state_d;
  logic [2:0]         p1_cnt_q, p1_cnt_d;
  logic [2:0]         p2_cnt_q, p2_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               goal_p1_q, goal_p1_d;
  logic               goal_p2_q, goal_p2_d;
  logic               puck_reset_q, puck_reset_d;
  logic               clear_sig_q, clear_sig_d;
  logic [1:0]         winner_q, winner_d;

  logic in_mouth, p2_hit, p1_hit;

  function automatic logic [2:0] sat_inc(input logic [2:0] c);
    return (c == 3'(WIN_SCORE)) ? c : c + 3'd1;
  endfunction

  function automatic logic [1:0] calc_winner(input logic [2:0] a, input logic [2:0] b);
    if (a > b)      return 2'b01;
    else if (b > a) return 2'b10;
    else            return 2'b11;
  endfunction

  // P2 owns the left goal; on a degenerate one-pixel field P2 wins the tie.
  assign in_mouth = (puck_y >= Y_W'(GOAL_Y_MIN)) && (puck_y <= Y_W'(GOAL_Y_MAX));
  assign p2_hit   = frame_tick && (puck_x == '0) && in_mouth;
  assign p1_hit   = frame_tick && (puck_x >= X_W'(SCREEN_W - 1)) && in_mouth && !p2_hit;

  always_comb begin
    // NOTE: every variable gets a default before the case so no latches are inferred.
    state_d      = state_q;
    p1_cnt_d     = p1_cnt_q;
    p2_cnt_d     = p2_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    winner_d     = winner_q;
    goal_p1_d    = 1'b0;
    goal_p2_d    = 1'b0;
    puck_reset_d = 1'b0;
    clear_sig_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The clear pulse cycle is spent in IDLE; PLAY begins right after it.
        if (clear_sig_q) begin
          state_d = S_PLAY;
        end else if (start) begin
          clear_sig_d = 1'b1;
          p1_cnt_d    = '0;
          p2_cnt_d    = '0;
          hold_cnt_d  = '0;
          winner_d    = 2'b00;
        end
      end

      S_PLAY: begin
        if (p2_hit) begin
          goal_p2_d    = 1'b1;
          puck_reset_d = 1'b1;
          p2_cnt_d     = sat_inc(p2_cnt_q);
          state_d      = S_HOLD;
        end else if (p1_hit) begin
          goal_p1_d    = 1'b1;
          puck_reset_d = 1'b1;
          p1_cnt_d     = sat_inc(p1_cnt_q);
          state_d      = S_HOLD;
        end
        if (time_expired) begin
          state_d  = S_OVER;
          winner_d = calc_winner(p1_cnt_d, p2_cnt_d);
        end
      end

      S_HOLD: begin
        if (frame_tick) begin
          if (hold_cnt_q == HOLD_W'(HOLD_FRAMES - 1)) begin
            hold_cnt_d = '0;
            if ((p1_cnt_q == 3'(WIN_SCORE)) || (p2_cnt_q == 3'(WIN_SCORE))) begin
              state_d  = S_OVER;
              winner_d = calc_winner(p1_cnt_q, p2_cnt_q);
            end else begin
              state_d = S_PLAY;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end

      S_OVER: begin
        if (start) begin
          clear_sig_d = 1'b1;
          p1_cnt_d    = '0;
          p2_cnt_d    = '0;
          hold_cnt_d  = '0;
          winner_d    = 2'b00;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      state_q      <= S_IDLE;
      p1_cnt_q     <= '0;
      p2_cnt_q     <= '0;
      hold_cnt_q   <= '0;
      goal_p1_q    <= 1'b0;
      goal_p2_q    <= 1'b0;
      puck_reset_q <= 1'b0;
      clear_sig_q  <= 1'b0;
      winner_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      p1_cnt_q     <= p1_cnt_d;
      p2_cnt_q     <= p2_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      goal_p1_q    <= goal_p1_d;
      goal_p2_q    <= goal_p2_d;
      puck_reset_q <= puck_reset_d;
      clear_sig_q  <= clear_sig_d;
      winner_q     <= winner_d;
    end
  end

  assign goal_p1      = goal_p1_q;
  assign goal_p2      = goal_p2_q;
  assign puck_reset   = puck_reset_q;
  assign clear_sig    = clear_sig_q;
  assign timer_enable = (state_q == S_PLAY);
  assign game_over    = (state_q == S_OVER);
  assign winner       = winner_q;

endmodule

// File: tb/tb_goal_referee.sv
// Self-checking bench for goal_referee: directed match scenarios followed by
// random frames, all compared against a frame-level model of the match rules.
module tb_goal_referee;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic [7:0] puck_x = '0;
  logic [6:0] puck_y = '0;
  logic       start = 1'b0;
  logic       time_expired = 1'b0;
  logic       goal_p1, goal_p2, puck_reset, timer_enable, clear_sig, game_over;
  logic [1:0] winner;

  goal_referee dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .frame_tick   (frame_tick),
    .puck_x       (puck_x),
    .puck_y       (puck_y),
    .start        (start),
    .time_expired (time_expired),
    .goal_p1      (goal_p1),
    .goal_p2      (goal_p2),
    .puck_reset   (puck_reset),
    .timer_enable (timer_enable),
    .clear_sig    (clear_sig),
    .game_over    (game_over),
    .winner       (winner)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef enum {M_IDLE, M_PLAY, M_HOLD, M_OVER} mode_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  mode_t      m_mode   = M_IDLE;
  int         m_p1     = 0;
  int         m_p2     = 0;
  int         m_hold_left = 0;
  logic [1:0] m_win    = 2'b00;

  // Output bundle: {goal_p1, goal_p2, puck_reset, timer_enable, clear_sig, game_over, winner}
  function automatic logic [7:0] obs();
    return {goal_p1, goal_p2, puck_reset, timer_enable, clear_sig, game_over, winner};
  endfunction

  function automatic logic [7:0] steady_exp();
    return {3'b000, m_mode == M_PLAY, 1'b0, m_mode == M_OVER,
            (m_mode == M_OVER) ? m_win : 2'b00};
  endfunction

  function automatic logic [1:0] winner_of(input int a, input int b);
    if (a > b) return 2'b01;
    if (b > a) return 2'b10;
    return 2'b11;
  endfunction

  task automatic check(input string tag, input logic [7:0] o, input logic [7:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b (g1 g2 pr te clr go win)", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    m_p1 = 0; m_p2 = 0; m_win = 2'b00;
    check({tag, "_clear"}, obs(), 8'b0000_1000);
    m_mode = M_PLAY;
    tick();
    check({tag, "_play"}, obs(), steady_exp());
  endtask

  // One frame_tick cycle, then the output cycle after it is checked against the
  // model; with tail set, one more quiet cycle is checked for pulse removal.
  task automatic frame(input string tag, input int x, input int y, input bit te, input bit tail);
    bit g1, g2;
    g1 = 1'b0; g2 = 1'b0;
    puck_x = 8'(x); puck_y = 7'(y); time_expired = te; frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0; time_expired = 1'b0;
    case (m_mode)
      M_PLAY: begin
        if (y >= 40 && y <= 80) begin
          if (x == 0)        g2 = 1'b1;
          else if (x >= 159) g1 = 1'b1;
        end
        if (g1) m_p1 = (m_p1 < 6) ? m_p1 + 1 : 6;
        if (g2) m_p2 = (m_p2 < 6) ? m_p2 + 1 : 6;
        if (te) begin
          m_mode = M_OVER;
          m_win  = winner_of(m_p1, m_p2);
        end else if (g1 || g2) begin
          m_mode = M_HOLD;
          m_hold_left = 30;
        end
      end
      M_HOLD: begin
        m_hold_left--;
        if (m_hold_left == 0) begin
          if (m_p1 == 6 || m_p2 == 6) begin
            m_mode = M_OVER;
            m_win  = winner_of(m_p1, m_p2);
          end else begin
            m_mode = M_PLAY;
          end
        end
      end
      default: ;
    endcase
    check(tag, obs(), {g1, g2, g1 | g2, m_mode == M_PLAY, 1'b0, m_mode == M_OVER,
                       (m_mode == M_OVER) ? m_win : 2'b00});
    if (tail) begin
      tick();
      check({tag, "_after"}, obs(), steady_exp());
    end
  endtask

  task automatic hold_out(input int x, input int y);
    while (m_mode == M_HOLD) frame("hold", x, y, 1'b0, 1'b1);
  endtask

  task automatic p1_goal();
    frame("p1_goal", 159, 60, 1'b0, 1'b1);
    hold_out(159, 60);
  endtask

  task automatic p2_goal();
    frame("p2_goal", 0, 60, 1'b0, 1'b1);
    hold_out(0, 60);
  endtask

  // Reset asserted away from a clock edge must clear outputs immediately.
  task automatic reset_mid(input string tag);
    reset_n = 1'b1;
    #1;
    check({tag, "_async"}, obs(), 8'h00);
    tick();
    reset_n = 1'b0;
    m_mode = M_IDLE; m_p1 = 0; m_p2 = 0; m_win = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check({tag, "_released"}, obs(), 8'h00);
    end
  endtask

  initial begin
    int x, y, r;
    bit te;

    #2;
    check("reset_hold", obs(), 8'h00);
    #10;
    reset_n = 1'b0;
    tick();
    check("idle_after_reset", obs(), 8'h00);

    do_start("start1");

    // Left goal, hold with the puck parked in the mouth (no double score).
    frame("p2_goal_y60", 0, 60, 1'b0, 1'b1);
    hold_out(0, 60);
    check("play_after_hold", obs(), 8'b0001_0000);

    // Wall contacts outside the mouth and at the mouth edges.
    frame("right_y20", 159, 20, 1'b0, 1'b1);
    frame("left_y39", 0, 39, 1'b0, 1'b1);
    frame("left_y81", 0, 81, 1'b0, 1'b1);
    frame("mid_field", 80, 60, 1'b0, 1'b1);
    frame("p1_goal_y80", 159, 80, 1'b0, 1'b1);
    hold_out(159, 60);

    // From 1-1 to 2-2, then a goal on the expiry frame skips HOLD.
    frame("p1_goal_x255_y40", 255, 40, 1'b0, 1'b1);
    hold_out(255, 40);
    p2_goal();
    frame("p2_goal_expired", 0, 50, 1'b1, 1'b1);
    check("over_winner_p2", obs(), 8'b0000_0110);

    // 2-2 draw at expiry.
    do_start("start2");
    p1_goal(); p1_goal(); p2_goal(); p2_goal();
    frame("draw_expired", 80, 60, 1'b1, 1'b1);
    check("over_winner_draw", obs(), 8'b0000_0111);

    // Six P1 goals end the match after the sixth hold.
    do_start("start3");
    for (int i = 0; i < 6; i++) p1_goal();
    check("over_winner_p1", obs(), 8'b0000_0101);
    frame("over_ignores_goal", 159, 60, 1'b1, 1'b1);
    do_start("restart_after_win");

    // Reset during HOLD, then during the goal pulse cycle itself.
    frame("goal_before_reset", 0, 60, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) frame("hold_before_reset", 0, 60, 1'b0, 1'b1);
    reset_mid("reset_in_hold");
    do_start("start4");
    frame("goal_pulse_then_reset", 159, 70, 1'b0, 1'b0);
    reset_mid("reset_in_pulse");

    // Random frames against the model.
    for (int i = 0; i < 700; i++) begin
      if (m_mode == M_IDLE || m_mode == M_OVER) do_start("rand_start");
      r = $urandom_range(0, 9);
      if (r < 3)      x = 0;
      else if (r < 6) x = $urandom_range(159, 255);
      else            x = $urandom_range(1, 158);
      r = $urandom_range(0, 7);
      case (r)
        0: y = 39;
        1: y = 40;
        2: y = 80;
        3: y = 81;
        default: y = $urandom_range(0, 127);
      endcase
      te = ($urandom_range(0, 59) == 0);
      frame("rand_frame", x, y, te, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
